// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access stage directly downstream of the 64-bit ALU.
// Loads and stores perform one byte-laned data-memory access over a req/ack
// handshake. Other opcodes pass alu_result through. Results go to writeback
// over a valid/ready handshake.
// Optional feature: define MEM_TIMEOUT_EN to enable the mem_ack watchdog.
module mem_access_stage #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        opcode,
   input  logic [63:0]       alu_result,
   input  logic [63:0]       store_data,
   input  logic [4:0]        dest_reg,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_be,
   output logic [63:0]       mem_wdata,
   input  logic [63:0]       mem_rdata,
   input  logic              mem_ack,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [63:0]       out_data,
   output logic [4:0]        out_dest,
   output logic              out_wen,
   output logic              out_err
);

   typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_e;

   // Access size codes are log2 of the byte count.
   localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3;

   localparam logic [5:0] OP_LWZ = 6'd32, OP_LBZ = 6'd34, OP_STW = 6'd36, OP_STWU = 6'd37,
                          OP_STB = 6'd38, OP_LHZ = 6'd40, OP_LHA = 6'd42, OP_STH  = 6'd44,
                          OP_LD  = 6'd58, OP_STD = 6'd62;

   if (ADDR_W < 4 || ADDR_W > 64 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("mem_access_stage: unsupported ADDR_W or TIMEOUT_CYCLES");
   end

   state_e              state_q, state_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [7:0]          mem_be_q, mem_be_d;
   logic [63:0]         mem_wdata_q, mem_wdata_d;
   logic [2:0]          lane_q, lane_d;
   logic [1:0]          size_q, size_d;
   logic                sign_q, sign_d;
   logic [63:0]         out_data_q, out_data_d;
   logic [4:0]          out_dest_q, out_dest_d;
   logic                out_wen_q, out_wen_d;
   logic                out_err_q, out_err_d;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
`endif

   logic                dec_mem, dec_store, dec_sign;
   logic [1:0]          dec_size;
   logic [2:0]          align_mask;
   logic [7:0]          be_base;
   logic [63:0]         size_mask;
   logic                misaligned;
   logic [63:0]         rdata_shifted, load_value;

   // Decode the incoming opcode into access size, direction and extension.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
      dec_mem   = 1'b1;
      dec_store = 1'b0;
      dec_sign  = 1'b0;
      dec_size  = SZ_D;
      case (opcode)
         OP_LD:           dec_size = SZ_D;
         OP_STD:          dec_store = 1'b1;
         OP_LWZ:          dec_size = SZ_W;
         OP_STW, OP_STWU: begin dec_size = SZ_W; dec_store = 1'b1; end
         OP_LHZ:          dec_size = SZ_H;
         OP_LHA:          begin dec_size = SZ_H; dec_sign = 1'b1; end
         OP_STH:          begin dec_size = SZ_H; dec_store = 1'b1; end
         OP_LBZ:          dec_size = SZ_B;
         OP_STB:          begin dec_size = SZ_B; dec_store = 1'b1; end
         default:         dec_mem = 1'b0;
      endcase
   end

   // Per-size lane masks for the alignment check, byte enables and store data.
   always_comb begin
      case (dec_size)
         SZ_B:    begin align_mask = 3'b000; be_base = 8'h01; size_mask = 64'h0000_0000_0000_00FF; end
         SZ_H:    begin align_mask = 3'b001; be_base = 8'h03; size_mask = 64'h0000_0000_0000_FFFF; end
         SZ_W:    begin align_mask = 3'b011; be_base = 8'h0F; size_mask = 64'h0000_0000_FFFF_FFFF; end
         default: begin align_mask = 3'b111; be_base = 8'hFF; size_mask = 64'hFFFF_FFFF_FFFF_FFFF; end
      endcase
      misaligned = |(alu_result[2:0] & align_mask);
   end

   // Right-align the addressed lanes of the read data and extend to 64 bits.
   always_comb begin
      rdata_shifted = mem_rdata >> {lane_q, 3'b000};
      case (size_q)
         SZ_B:    load_value = {56'd0, rdata_shifted[7:0]};
         SZ_H:    load_value = sign_q ? {{48{rdata_shifted[15]}}, rdata_shifted[15:0]}
                                      : {48'd0, rdata_shifted[15:0]};
         SZ_W:    load_value = {32'd0, rdata_shifted[31:0]};
         default: load_value = rdata_shifted;
      endcase
   end

   // Next-state and output logic of the IDLE -> (MEM) -> RESP sequence.
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      lane_d      = lane_q;
      size_d      = size_q;
      sign_d      = sign_q;
      out_data_d  = out_data_q;
      out_dest_d  = out_dest_q;
      out_wen_d   = out_wen_q;
      out_err_d   = out_err_q;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_d   = tmo_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               out_dest_d = dest_reg;
               lane_d     = alu_result[2:0];
               size_d     = dec_size;
               sign_d     = dec_sign;
               if (!dec_mem) begin
                  out_data_d = alu_result;
                  out_wen_d  = 1'b1;
                  out_err_d  = 1'b0;
                  state_d    = S_RESP;
               end else if (misaligned) begin
                  out_data_d = 64'd0;
                  out_wen_d  = 1'b0;
                  out_err_d  = 1'b1;
                  state_d    = S_RESP;
               end else begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = dec_store;
                  mem_addr_d  = {alu_result[ADDR_W-1:3], 3'b000};
                  mem_be_d    = be_base << alu_result[2:0];
                  mem_wdata_d = dec_store ? (store_data & size_mask) << {alu_result[2:0], 3'b000} : 64'd0;
                  state_d     = S_MEM;
`ifdef MEM_TIMEOUT_EN
                  tmo_cnt_d   = '0;
`endif
               end
            end
         end
         S_MEM: begin
            if (mem_ack) begin
               {mem_req_d, mem_we_d, mem_be_d} = '0;
               mem_addr_d  = '0;
               mem_wdata_d = 64'd0;
               out_data_d  = mem_we_q ? 64'd0 : load_value;
               out_wen_d   = !mem_we_q;
               out_err_d   = 1'b0;
               state_d     = S_RESP;
            end
`ifdef MEM_TIMEOUT_EN
            else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               {mem_req_d, mem_we_d, mem_be_d} = '0;
               mem_addr_d  = '0;
               mem_wdata_d = 64'd0;
               out_data_d  = 64'd0;
               out_wen_d   = 1'b0;
               out_err_d   = 1'b1;
               state_d     = S_RESP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
            end
`endif
         end
         S_RESP: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; synchronous reset abandons any access.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q     <= S_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= 8'd0;
         mem_wdata_q <= 64'd0;
         lane_q      <= 3'd0;
         size_q      <= SZ_B;
         sign_q      <= 1'b0;
         out_data_q  <= 64'd0;
         out_dest_q  <= 5'd0;
         out_wen_q   <= 1'b0;
         out_err_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         tmo_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         lane_q      <= lane_d;
         size_q      <= size_d;
         sign_q      <= sign_d;
         out_data_q  <= out_data_d;
         out_dest_q  <= out_dest_d;
         out_wen_q   <= out_wen_d;
         out_err_q   <= out_err_d;
`ifdef MEM_TIMEOUT_EN
         tmo_cnt_q   <= tmo_cnt_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_RESP);
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;
   assign out_data  = out_data_q;
   assign out_dest  = out_dest_q;
   assign out_wen   = out_wen_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: random and directed stimulus for mem_access_stage.
// Expected memory requests and writeback results are queued at issue time by a
// byte-level reference model; a memory responder and an output monitor pop
// and compare them whenever the DUT presents a request or a result.
module tb_mem_access_stage;
   localparam int ADDR_W = 32;
   localparam int TMO    = 4;
   localparam int RAND   = -1;
   localparam int HANG   = -2;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [5:0]        opcode;
   logic [63:0]       alu_result;
   logic [63:0]       store_data;
   logic [4:0]        dest_reg;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_be;
   logic [63:0]       mem_wdata;
   logic [63:0]       mem_rdata;
   logic              mem_ack;
   logic              out_valid;
   logic              out_ready;
   logic [63:0]       out_data;
   logic [4:0]        out_dest;
   logic              out_wen;
   logic              out_err;

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   mem_access_stage #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .alu_result(alu_result), .store_data(store_data),
      .dest_reg(dest_reg), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_dest(out_dest),
      .out_wen(out_wen), .out_err(out_err)
   );

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        be;
      logic [63:0]       wdata;
      logic [63:0]       rdata;
   } mem_exp_t;

   typedef struct packed {
      logic [63:0] data;
      logic [4:0]  dest;
      logic        wen;
      logic        err;
   } out_exp_t;

   mem_exp_t   mem_q[$];
   out_exp_t   out_q[$];
   int         checks = 0;
   int         passed = 0;
   int         ack_delay = 0;
   int         rdy_low = 0;
   bit         late_ack = 1'b0;
   int         last_req_cycles = 0;
   logic [5:0] mem_ops [10] = '{6'd58, 6'd62, 6'd32, 6'd36, 6'd37, 6'd40, 6'd42, 6'd44, 6'd34, 6'd38};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic int op_bytes(input logic [5:0] op);
      case (op)
         6'd58, 6'd62:        return 8;
         6'd32, 6'd36, 6'd37: return 4;
         6'd40, 6'd42, 6'd44: return 2;
         6'd34, 6'd38:        return 1;
         default:             return 0;
      endcase
   endfunction

   function automatic bit op_is_store(input logic [5:0] op);
      return op inside {6'd62, 6'd36, 6'd37, 6'd44, 6'd38};
   endfunction

   // Queue the expected request/result for one instruction, then drive it until accepted.
   task automatic issue(input logic [5:0] op, input logic [63:0] alu, input logic [63:0] sd,
                        input logic [4:0] dst, input logic [63:0] rdata, input bit tmo);
      int          nb;
      int          lane;
      int          n;
      out_exp_t    oe;
      mem_exp_t    me;
      logic [63:0] v;
      logic [63:0] mask;
      nb      = op_bytes(op);
      lane    = int'(alu[2:0]);
      oe      = '0;
      oe.dest = dst;
      if (nb == 0) begin
         oe.data = alu;
         oe.wen  = 1'b1;
      end else if (lane % nb != 0) begin
         oe.err = 1'b1;
      end else begin
         me.we       = op_is_store(op);
         me.addr     = alu[ADDR_W-1:0];
         me.addr[2:0] = 3'd0;
         me.be       = 8'(((1 << nb) - 1) << lane);
         mask        = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
         me.wdata    = me.we ? ((sd & mask) << (8 * lane)) : 64'd0;
         me.rdata    = rdata;
         v = 64'd0;
         for (int i = 0; i < nb; i++) v |= 64'(rdata[8 * (lane + i) +: 8]) << (8 * i);
         if (op == 6'd42 && v[15]) v |= ~64'hFFFF;
         if (tmo) oe.err = 1'b1;
         else if (!me.we) begin
            oe.data = v;
            oe.wen  = 1'b1;
         end
         mem_q.push_back(me);
      end
      out_q.push_back(oe);
      @(negedge clk);
      opcode     = op;
      alu_result = alu;
      store_data = sd;
      dest_reg   = dst;
      in_valid   = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait", in_ready, 1);
      @(negedge clk);
      in_valid   = 1'b0;
      opcode     = 6'($urandom);
      alu_result = {$urandom, $urandom};
      store_data = {$urandom, $urandom};
      dest_reg   = 5'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (out_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain", out_q.size(), 0);
   endtask

   task automatic check_reset_outputs();
      check("rst_in_ready", in_ready, 1);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_be", mem_be, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_wen", out_wen, 0);
      check("rst_out_err", out_err, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_dest", out_dest, 0);
   endtask

   // Memory responder: checks each request cycle against the queue and acks after a delay.
   initial begin : responder
      mem_exp_t me;
      int       delay;
      int       w;
      mem_ack   = 1'b0;
      mem_rdata = 64'd0;
      forever begin
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = {$urandom, $urandom};
         if (late_ack) begin
            mem_ack  = 1'b1;
            late_ack = 1'b0;
         end else if (mem_req && !rst) begin
            if (mem_q.size() == 0) begin
               check("unexpected_mem_req", mem_req, 0);
               me = '0;
            end else begin
               me = mem_q.pop_front();
            end
            delay = (ack_delay == RAND) ? int'($urandom_range(0, 3)) : ack_delay;
            w = 0;
            forever begin
               check("mem_req", mem_req, 1);
               check("mem_we", mem_we, me.we);
               check("mem_addr", mem_addr, me.addr);
               check("mem_be", mem_be, me.be);
               check("mem_wdata", mem_wdata, me.wdata);
               if (w == delay) begin
                  mem_ack         = 1'b1;
                  mem_rdata       = me.rdata;
                  last_req_cycles = w + 1;
                  break;
               end
               @(negedge clk);
               mem_rdata = {$urandom, $urandom};
               w++;
               if (!mem_req) begin
                  last_req_cycles = w;
                  if (ack_delay != HANG) check("mem_req_dropped", mem_req, 1);
                  break;
               end
            end
         end
      end
   end

   // Output monitor: drives out_ready and compares every valid cycle with the queue head.
   initial begin : out_monitor
      out_exp_t oe;
      int       valid_cnt = 0;
      bit       handshake = 1'b0;
      out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (handshake) begin
            check("in_ready_after_out", in_ready, 1);
            check("out_valid_drop", out_valid, 0);
            handshake = 1'b0;
         end
         if (out_valid && !rst) begin
            if (rdy_low == RAND) out_ready = ($urandom_range(0, 2) != 0);
            else out_ready = (valid_cnt >= rdy_low);
            valid_cnt++;
            check("in_ready_busy", in_ready, 0);
            if (out_q.size() == 0) begin
               check("unexpected_out_valid", out_valid, 0);
            end else begin
               oe = out_q[0];
               check("out_data", out_data, oe.data);
               check("out_dest", out_dest, oe.dest);
               check("out_wen", out_wen, oe.wen);
               check("out_err", out_err, oe.err);
               if (out_ready) begin
                  oe        = out_q.pop_front();
                  handshake = 1'b1;
                  valid_cnt = 0;
               end
            end
         end else begin
            out_ready = 1'($urandom_range(0, 1));
            valid_cnt = 0;
         end
      end
   end

   // Hard time limit so a stuck DUT still ends the run.
   initial begin : watchdog
      #800_000;
      $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", passed, checks);
      $fatal(1, "watchdog expired");
   end

   // Directed cases, random traffic, reset mid-access and the optional watchdog case.
   initial begin : main
      logic [5:0]  op;
      logic [63:0] alu;
      int          nb;
      int          pick;
      rst        = 1'b1;
      in_valid   = 1'b0;
      opcode     = 6'd0;
      alu_result = 64'd0;
      store_data = 64'd0;
      dest_reg   = 5'd0;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst = 1'b0;

      ack_delay = 0;
      rdy_low   = 0;
      issue(6'd14, 64'h1234, 64'd0, 5'd5, 64'd0, 1'b0);
      check("pass_latency", out_valid, 1);

      issue(6'd42, 64'h106, 64'd0, 5'd9, 64'h8001_0000_0000_0000, 1'b0);
      check("lha_req_cycle", mem_req, 1);
      check("lha_not_early", out_valid, 0);
      @(negedge clk);
      check("lha_latency", out_valid, 1);

      issue(6'd38, 64'h203, 64'hAB, 5'd3, {$urandom, $urandom}, 1'b0);
      issue(6'd32, 64'h2, 64'd0, 5'd4, 64'd0, 1'b0);
      check("misaligned_no_req", mem_req, 0);
      check("misaligned_latency", out_valid, 1);

      ack_delay = 3;
      rdy_low   = 4;
      issue(6'd58, 64'h0000_0040_1234_5678, 64'd0, 5'd12, {$urandom, $urandom}, 1'b0);
      issue(6'd44, 64'h0000_0000_0000_0ACE, 64'h1357_9BDF_2468_ACE0, 5'd13, 64'd0, 1'b0);
      drain();

      ack_delay = RAND;
      rdy_low   = RAND;
      repeat (300) begin
         pick = int'($urandom_range(0, 12));
         if (pick < 10) begin
            op = mem_ops[pick];
         end else begin
            do op = 6'($urandom); while (op_bytes(op) != 0);
         end
         alu = {$urandom, $urandom};
         nb  = op_bytes(op);
         if (nb != 0 && $urandom_range(0, 3) != 0) alu[2:0] = 3'((int'($urandom_range(0, 7)) / nb) * nb);
         issue(op, alu, {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom}, 1'b0);
      end
      drain();

      ack_delay = HANG;
      rdy_low   = 0;
      issue(6'd58, 64'h3F8, 64'd0, 5'd7, {$urandom, $urandom}, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs();
      rst = 1'b0;
      out_q.delete();
      mem_q.delete();
      late_ack = 1'b1;
      repeat (3) @(negedge clk);
      check("late_ack_out_valid", out_valid, 0);
      check("late_ack_in_ready", in_ready, 1);
      check("late_ack_mem_req", mem_req, 0);
      ack_delay = 0;
      issue(6'd34, 64'h0000_0000_0000_0805, 64'd0, 5'd21, 64'h00FF_EEDD_CCBB_AA99, 1'b0);
      drain();

`ifdef MEM_TIMEOUT_EN
      ack_delay = HANG;
      issue(6'd58, 64'h500, 64'd0, 5'd11, 64'd0, 1'b1);
      drain();
      check("tmo_req_cycles", last_req_cycles, TMO);
      ack_delay = 0;
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Datapath stage directly downstream of the 64-bit ALU.
- Takes the ALU result and opcode. For load/store opcodes it uses the ALU result as the effective address and performs one access to a 64-bit, byte-laned data memory through a req/ack handshake.
- For loads, it extracts and zero- or sign-extends the data. It hands the result to writeback through a valid/ready handshake.
- For non-memory opcodes, it passes the ALU result through to writeback.

Parameters:
- ADDR_W, 32, width of mem_addr; effective address truncated to its low ADDR_W bits.
- TIMEOUT_CYCLES, 64, ack watchdog limit; used only with MEM_TIMEOUT_EN.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  stage can accept; high only in IDLE.
- opcode  input  6  primary opcode from the ALU stage.
- alu_result  input  64  effective address for memory ops; result value otherwise.
- store_data  input  64  source register value for stores.
- dest_reg  input  5  writeback register index.
- mem_req  output  1  memory request, held until mem_ack.
- mem_we  output  1  1 = store.
- mem_addr  output  ADDR_W  doubleword-aligned address (low 3 bits zero).
- mem_be  output  8  byte enables; bit i = byte lane i.
- mem_wdata  output  64  store data, lane-shifted.
- mem_rdata  input  64  read data, valid in the cycle mem_ack is high.
- mem_ack  input  1  single-cycle completion pulse.
- out_valid  output  1  result available to writeback.
- out_ready  input  1  writeback accepts.
- out_data  output  64  load/pass-through result.
- out_dest  output  5  latched dest_reg.
- out_wen  output  1  register write required (loads and non-memory ops only).
- out_err  output  1  misaligned access or timeout; out_wen forced 0.

Behaviour:
- Reset: state = IDLE.
  - in_ready=1 after reset.
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata = 0.
  - out_valid, out_wen, out_err = 0; out_data, out_dest = 0.
  - Reset mid-access abandons the transaction; a late mem_ack after reset is ignored.
- Byte order and sizes: little-endian lanes; lane = alu_result[2:0].
  - Size 8: opcodes 58 (LD), 62 (STD).
  - Size 4: opcodes 32 (LWZ), 36 (STW), 37 (STWU).
  - Size 2: opcodes 40 (LHZ), 42 (LHA), 44 (STH).
  - Size 1: opcodes 34 (LBZ), 38 (STB).
- Extension: LHA sign-extends from bit 15; all other loads zero-extend.
- Stores: write store_data's low size bytes; shift left by lane×8; mem_be covers exactly those lanes.
- FSM states: IDLE, MEM, RESP.
- IDLE transitions, on in_valid (capture all inputs on that edge):
  - Non-memory opcode → RESP next cycle. out_data = alu_result, out_wen=1.
  - Memory op with lane not a multiple of size → RESP. out_err=1, out_wen=0, no memory request issued.
  - Aligned memory op → MEM. mem_req=1 from the next cycle.
- MEM:
  - mem_req and all mem_* outputs stay stable until the cycle mem_ack=1.
  - On ack: mem_req drops next cycle; go to RESP.
  - Load: out_data = extracted, extended rdata; out_wen=1.
  - Store: out_data=0, out_wen=0.
- RESP:
  - out_valid=1; outputs held stable while out_ready=0.
  - On out_ready: IDLE next cycle; out_valid drops.
- Minimum latency:
  - Pass-through: accept at edge N, out_valid from N+1.
  - Memory with same-cycle ack: req at N+1, ack at N+1, out_valid at N+2.
- No overlap: in_ready=0 outside IDLE, so back-to-back throughput is one instruction per 2 cycles minimum.
- mem_ack outside MEM is ignored.
- STWU is treated as STW; the base-register update is not handled here.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- When defined:
  - A counter clears on entering MEM and increments each MEM cycle without ack.
  - If it reaches TIMEOUT_CYCLES: deassert mem_req, go to RESP with out_err=1, out_wen=0, out_data=0.
  - An ack arriving in the same cycle as the limit wins; the access completes normally.
- When undefined: no counter, and the stage waits indefinitely for mem_ack.

Test Plan:
- Pass-through: opcode 14, alu_result=0x1234, dest 5, out_ready=1 → out_valid one cycle after accept; out_data=0x1234, out_dest=5, out_wen=1, mem_req never asserted.
- LHA: alu_result=0x106, mem_rdata=0x8001_0000_0000_0000, same-cycle ack → mem_addr=0x100, mem_be=0xC0, out_data=0xFFFF_FFFF_FFFF_8001.
- STB: alu_result=0x203, store_data=0xAB → mem_we=1, mem_addr=0x200, mem_be=0x08, mem_wdata=0xAB00_0000, out_wen=0.
- Misaligned LWZ: alu_result=0x2 → no mem_req, out_err=1, out_wen=0.
- Backpressure: ack delayed 3 cycles and out_ready low 4 cycles → mem_* and out_* stable throughout; in_ready=0 until the cycle after out_ready.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack → mem_req high exactly 4 cycles, then out_err=1. Separately, asserting rst mid-MEM → all outputs at reset values next cycle.
